// File: rtl/cb_cfg_pkg.sv
// Shared types and constants for the connection-block configuration loader.
// Holds the sequencer state encoding, default chain geometry and counter width helper.
package cb_cfg_pkg;

  localparam int unsigned CB_BITS_DEFAULT = 96;
  localparam int unsigned CB_NUM_DEFAULT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_e;

  // Bits needed to hold a count from 0 up to and including max_val (never below 1).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : int'($clog2(max_val + 1));
  endfunction

endpackage

// File: rtl/cb_config_loader_if.sv
// Word-source handshake plus the serial programming lines shared by the CB chain.
// The loader uses the master view; the source/chain side uses the slave view.
interface cb_config_loader_if #(
  parameter int unsigned WORD_W = 32
);

  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              bit_in;
  logic              bit_valid;
  logic              prgm_b;
  logic              cb_prgm_b;
  logic              cb_prgm_b_in;

  modport master (
    input  word_data,
    input  word_valid,
    output word_ready,
    output bit_in,
    output bit_valid,
    output prgm_b,
    output cb_prgm_b,
    output cb_prgm_b_in
  );

  modport slave (
    output word_data,
    output word_valid,
    input  word_ready,
    input  bit_in,
    input  bit_valid,
    input  prgm_b,
    input  cb_prgm_b,
    input  cb_prgm_b_in
  );

endinterface

// File: rtl/cfg_word_serializer.sv
// Parallel-load, LSB-first shift register with a bits-remaining counter.
// bit_out is the register LSB, so it reads 0 once a word has been fully shifted out.
module cfg_word_serializer
  import cb_cfg_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  output logic              bit_out,
  output logic              empty,
  output logic              last
);

  localparam int unsigned CNT_W = cnt_w(WORD_W);

  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  remaining;

  // clear beats load beats shift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      remaining <= '0;
    end else if (clear) begin
      shreg     <= '0;
      remaining <= '0;
    end else if (load) begin
      shreg     <= load_data;
      remaining <= CNT_W'(WORD_W);
    end else if (shift) begin
      shreg     <= shreg >> 1;
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign bit_out = shreg[0];
  assign empty   = (remaining == '0);
  assign last    = (remaining == CNT_W'(1));

endmodule

// File: rtl/cb_config_loader.sv
// Configuration sequencer for the connection-block chain: fetches words, shifts them
// out LSB-first, counts bits per CB and inserts one gap cycle between blocks.
module cb_config_loader
  import cb_cfg_pkg::*;
#(
  parameter int unsigned BITS_PER_CB = CB_BITS_DEFAULT,
  parameter int unsigned NUM_CB      = CB_NUM_DEFAULT,
  parameter int unsigned WORD_W      = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  cb_config_loader_if.master          bus,
  output logic                        cb_adv,
  output logic [cnt_w(NUM_CB)-1:0]    cb_index,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned BIT_W = cnt_w(BITS_PER_CB);
  localparam int unsigned IDX_W = cnt_w(NUM_CB);

  state_e           state;
  state_e           state_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_cnt_nxt;
  logic [IDX_W-1:0] cb_index_nxt;

  logic handshake;
  logic ser_load;
  logic ser_shift;
  logic ser_clear;
  logic ser_bit;
  logic ser_empty;
  logic ser_last;

  logic valid_nxt;
  logic adv_nxt;
  logic done_nxt;
  logic busy_nxt;

  // word_ready is a pure state decode so the source sees it in the FETCH cycle itself
  assign bus.word_ready = (state == ST_FETCH);
  assign handshake      = bus.word_ready & bus.word_valid;

  cfg_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .clear     (ser_clear),
    .load      (ser_load),
    .load_data (bus.word_data),
    .shift     (ser_shift),
    .bit_out   (ser_bit),
    .empty     (ser_empty),
    .last      (ser_last)
  );

  assign bus.bit_in = ser_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    cb_index_nxt = cb_index;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;
    ser_clear    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt    = ST_FETCH;
          bit_cnt_nxt  = '0;
          cb_index_nxt = '0;
        end
      end
      ST_FETCH: begin
        if (handshake) begin
          ser_load  = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_shift   = ~ser_empty;
        bit_cnt_nxt = bit_cnt + BIT_W'(1);
        // decide on the last bit of the word: refill, or close out the CB
        if (ser_last) begin
          state_nxt = (bit_cnt == BIT_W'(BITS_PER_CB - 1)) ? ST_GAP : ST_FETCH;
        end
      end
      ST_GAP: begin
        bit_cnt_nxt  = '0;
        cb_index_nxt = cb_index + IDX_W'(1);
        state_nxt    = (cb_index == IDX_W'(NUM_CB - 1)) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        cb_index_nxt = '0;
        state_nxt    = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // abort overrides everything, including a start seen in the same IDLE cycle
    if (abort) begin
      state_nxt    = ST_IDLE;
      bit_cnt_nxt  = '0;
      cb_index_nxt = '0;
      ser_load     = 1'b0;
      ser_shift    = 1'b0;
      ser_clear    = 1'b1;
    end

    valid_nxt = (state_nxt == ST_SHIFT);
    adv_nxt   = (state_nxt == ST_GAP);
    done_nxt  = (state_nxt == ST_DONE);
    busy_nxt  = (state_nxt == ST_FETCH) || (state_nxt == ST_SHIFT) || (state_nxt == ST_GAP);
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.bit_valid    <= 1'b0;
      bus.prgm_b       <= 1'b1;
      bus.cb_prgm_b    <= 1'b0;
      bus.cb_prgm_b_in <= 1'b0;
      cb_adv           <= 1'b0;
      done             <= 1'b0;
      busy             <= 1'b0;
      bit_cnt          <= '0;
      cb_index         <= '0;
    end else begin
      bus.bit_valid    <= valid_nxt;
      bus.prgm_b       <= ~busy_nxt;
      bus.cb_prgm_b    <= busy_nxt;
      bus.cb_prgm_b_in <= busy_nxt;
      cb_adv           <= adv_nxt;
      done             <= done_nxt;
      busy             <= busy_nxt;
      bit_cnt          <= bit_cnt_nxt;
      cb_index         <= cb_index_nxt;
    end
  end

endmodule

// File: tb/tb_cb_config_loader.sv
// Directed bench for cb_config_loader: table of full loads plus abort, async reset
// and a single-CB/single-word instance.
module tb_cb_config_loader;
  import cb_cfg_pkg::*;

  localparam int unsigned WW = 32;
  localparam int NW = 6;

  logic clk = 1'b0;
  logic reset;

  logic       start_a, abort_a, cb_adv_a, busy_a, done_a;
  logic [1:0] cb_index_a;
  logic       start_b, abort_b, cb_adv_b, busy_b, done_b;
  logic [0:0] cb_index_b;

  cb_config_loader_if #(.WORD_W(WW)) a_if ();
  cb_config_loader_if #(.WORD_W(WW)) b_if ();

  cb_config_loader #(
    .BITS_PER_CB (96),
    .NUM_CB      (2),
    .WORD_W      (WW)
  ) dut_a (
    .clk      (clk),
    .reset    (reset),
    .start    (start_a),
    .abort    (abort_a),
    .bus      (a_if),
    .cb_adv   (cb_adv_a),
    .cb_index (cb_index_a),
    .busy     (busy_a),
    .done     (done_a)
  );

  cb_config_loader #(
    .BITS_PER_CB (32),
    .NUM_CB      (1),
    .WORD_W      (WW)
  ) dut_b (
    .clk      (clk),
    .reset    (reset),
    .start    (start_b),
    .abort    (abort_b),
    .bus      (b_if),
    .cb_adv   (cb_adv_b),
    .cb_index (cb_index_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [WW-1:0] words [NW];
  int widx, stall_left, cyc;
  int prgm_low, adv_cnt, nbits, bit_err, vf_cnt, done_cyc, done_idx;

  typedef struct {
    string name;
    int    stall;
    int    busy_at;
    int    exp_done;
    int    exp_low;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_bit(input int i);
    logic [WW-1:0] w;
    w = words[(i / WW) % NW];
    return int'(w[i % WW]);
  endfunction

  task automatic sample_a();
    if (!a_if.prgm_b) prgm_low++;
    if (cb_adv_a) adv_cnt++;
    if (a_if.bit_valid) begin
      if (int'(a_if.bit_in) != exp_bit(nbits)) bit_err++;
      nbits++;
      if (a_if.word_ready) vf_cnt++;
    end
    if (done_a && done_cyc < 0) begin
      done_cyc = cyc;
      done_idx = int'(cb_index_a);
    end
  endtask

  task automatic drive_src();
    if (a_if.word_ready && widx < NW) begin
      if (widx == 1 && stall_left > 0) begin
        stall_left--;
        a_if.word_valid = 1'b0;
        a_if.word_data  = 32'hDEAD_BEEF;
      end else begin
        a_if.word_valid = 1'b1;
        a_if.word_data  = words[widx];
        widx++;
      end
    end else begin
      a_if.word_valid = 1'b0;
      a_if.word_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
    sample_a();
    drive_src();
  endtask

  // Called at a negedge with DUT A idle; this cycle is cycle 1 (start asserted).
  task automatic begin_load(input int stall_len);
    prgm_low = 0; adv_cnt = 0; nbits = 0; bit_err = 0; vf_cnt = 0;
    done_cyc = -1; done_idx = -1;
    widx = 0; stall_left = stall_len; cyc = 1;
    a_if.word_valid = 1'b0;
    start_a = 1'b1;
  endtask

  task automatic run_load(input int stall_len, input int busy_at, input int budget);
    begin_load(stall_len);
    while (done_cyc < 0 && cyc < budget) begin
      next_cycle();
      start_a = (cyc == busy_at) ? 1'b1 : 1'b0;
    end
    start_a = 1'b0;
  endtask

  task automatic check_run(input string tag, input int exp_done, input int exp_low);
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_done_index"}, done_idx, 2);
    chk({tag, "_cb_adv_pulses"}, adv_cnt, 2);
    chk({tag, "_prgm_b_low"}, prgm_low, exp_low);
    chk({tag, "_bit_count"}, nbits, 192);
    chk({tag, "_bit_errors"}, bit_err, 0);
    chk({tag, "_valid_in_fetch"}, vf_cnt, 0);
    chk({tag, "_words_taken"}, widx, NW);
    next_cycle();
    chk({tag, "_idle_prgm_b"}, int'(a_if.prgm_b), 1);
    chk({tag, "_idle_busy"}, int'(busy_a), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_prgm_b"}, int'(a_if.prgm_b), 1);
    chk({tag, "_cb_prgm_b"}, int'(a_if.cb_prgm_b), 0);
    chk({tag, "_cb_prgm_b_in"}, int'(a_if.cb_prgm_b_in), 0);
    chk({tag, "_bit_in"}, int'(a_if.bit_in), 0);
    chk({tag, "_bit_valid"}, int'(a_if.bit_valid), 0);
    chk({tag, "_word_ready"}, int'(a_if.word_ready), 0);
    chk({tag, "_cb_adv"}, int'(cb_adv_a), 0);
    chk({tag, "_cb_index"}, int'(cb_index_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] b_word;
    int cyc_b, fetch_b, nb, berr_b, adv_b, done_cyc_b, idx_b;

    vecs[0] = '{name: "nominal",    stall: 0, busy_at: 0,   exp_done: 202, exp_low: 200};
    vecs[1] = '{name: "stall7",     stall: 7, busy_at: 0,   exp_done: 209, exp_low: 207};
    vecs[2] = '{name: "busy_start", stall: 0, busy_at: 30,  exp_done: 202, exp_low: 200};
    vecs[3] = '{name: "stall3_bs",  stall: 3, busy_at: 150, exp_done: 205, exp_low: 203};

    words[0] = 32'h0000_0001; words[1] = 32'h0000_0000; words[2] = 32'h8000_0000;
    words[3] = 32'h0000_0001; words[4] = 32'h0000_0000; words[5] = 32'h8000_0000;

    reset = 1'b0;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    a_if.word_valid = 1'b0; a_if.word_data = '0;
    b_if.word_valid = 1'b0; b_if.word_data = '0;
    widx = 0; stall_left = 0; cyc = 0;

    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      run_load(vecs[v].stall, vecs[v].busy_at, 400);
      check_run(vecs[v].name, vecs[v].exp_done, vecs[v].exp_low);
    end

    // Abort while bit 50 of CB 0 is on the line.
    begin_load(0);
    while (cyc < 54) begin
      next_cycle();
      start_a = 1'b0;
    end
    chk("abort_bits_seen", nbits, 51);
    chk("abort_bit_valid_before", int'(a_if.bit_valid), 1);
    abort_a = 1'b1;
    next_cycle();
    abort_a = 1'b0;
    check_reset_vals("abort");

    // abort and start together in IDLE: stay idle
    start_a = 1'b1;
    abort_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("abort_start_busy", int'(busy_a), 0);
    chk("abort_start_prgm_b", int'(a_if.prgm_b), 1);
    chk("abort_start_word_ready", int'(a_if.word_ready), 0);

    run_load(0, 0, 400);
    check_run("post_abort", 202, 200);

    // Asynchronous reset between clock edges, mid-SHIFT.
    begin_load(0);
    while (cyc < 20) begin
      next_cycle();
      start_a = 1'b0;
    end
    chk("pre_reset_bit_valid", int'(a_if.bit_valid), 1);
    chk("pre_reset_prgm_b", int'(a_if.prgm_b), 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_load(0, 0, 400);
    check_run("post_reset", 202, 200);

    // Single CB of one word on the second instance.
    b_word = 32'hA5C3_0F81;
    cyc_b = 1; fetch_b = 0; nb = 0; berr_b = 0; adv_b = 0; done_cyc_b = -1; idx_b = -1;
    start_b = 1'b1;
    while (done_cyc_b < 0 && cyc_b < 100) begin
      @(negedge clk);
      cyc_b++;
      start_b = 1'b0;
      if (b_if.word_ready) fetch_b++;
      if (b_if.bit_valid) begin
        if (nb >= 32 || b_if.bit_in != b_word[nb]) berr_b++;
        nb++;
      end
      if (cb_adv_b) adv_b++;
      if (done_b) begin
        done_cyc_b = cyc_b;
        idx_b = int'(cb_index_b);
      end
      if (b_if.word_ready) begin
        b_if.word_valid = 1'b1;
        b_if.word_data  = b_word;
      end else begin
        b_if.word_valid = 1'b0;
        b_if.word_data  = '0;
      end
    end
    chk("single_done_cycle", done_cyc_b, 36);
    chk("single_fetch_cycles", fetch_b, 1);
    chk("single_bit_count", nb, 32);
    chk("single_bit_errors", berr_b, 0);
    chk("single_cb_adv", adv_b, 1);
    chk("single_done_index", idx_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cb_config_loader.md
# cb_config_loader

Configuration sequencer for the chain of `config_cb_behav` connection blocks. It accepts configuration words from a word-wide source, serialises them LSB-first onto the shared `bit_in` line, and drives `prgm_b`, `cb_prgm_b` and the chain-head `cb_prgm_b_in`. It counts `BITS_PER_CB` bits per connection block and inserts one gap cycle between blocks. It replaces the ad-hoc counter/shift logic currently in benches and sits between the bitstream store and the CB chain.

## Interface
- `BITS_PER_CB`, 96, configuration bits per connection block; must be a multiple of `WORD_W`
- `NUM_CB`, 2, number of connection blocks in the chain
- `WORD_W`, 32, source word width
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin programming; honoured only in IDLE
- `abort`  in  1  forces return to IDLE from any state at the next edge
- `word_data`  in  WORD_W  configuration word; bit 0 is shifted out first
- `word_valid`  in  1  source holds `word_data` valid
- `word_ready`  out  1  loader accepts a word this cycle (handshake: valid && ready)
- `bit_in`  out  1  serial configuration bit to all CBs
- `bit_valid`  out  1  `bit_in` carries a real bit this cycle
- `prgm_b`  out  1  active-low programming window
- `cb_prgm_b`  out  1  active-high CB programming enable
- `cb_prgm_b_in`  out  1  enable token into the first CB of the chain
- `cb_adv`  out  1  one-cycle pulse in the gap cycle after each completed CB
- `cb_index`  out  $clog2(NUM_CB+1)  index of the CB being loaded
- `busy`  out  1  high outside IDLE/DONE
- `done`  out  1  one-cycle pulse when the last CB completes

## Operation
- Reset values: `prgm_b`=1; `cb_prgm_b`=0; `cb_prgm_b_in`=0; `bit_in`=0; `bit_valid`=0; `word_ready`=0; `cb_adv`=0; `cb_index`=0; `busy`=0; `done`=0; all counters 0.
- States:
  - IDLE -> FETCH on `start`.
  - FETCH: `word_ready`=1; on handshake, load the shift register and go to SHIFT.
  - SHIFT: for each of `WORD_W` cycles, output the register LSB on `bit_in` with `bit_valid`=1, then shift right.
    - Word exhausted and bits remain in the current CB -> FETCH.
    - CB bit count reaches `BITS_PER_CB` -> GAP.
  - GAP: one cycle with `bit_valid`=0 and `cb_adv`=1; `cb_index` increments.
    - `cb_index` reaches `NUM_CB` -> DONE; otherwise -> FETCH.
  - DONE: `done`=1 for one cycle -> IDLE.
- `prgm_b`=0, `cb_prgm_b`=1 and `cb_prgm_b_in`=1 in every state except IDLE and DONE.
- Bit counter width is $clog2(BITS_PER_CB+1); it clears in GAP.
- Source stall: FETCH holds indefinitely while `word_valid`=0. `bit_valid`=0 and all counters hold.
- `start` while busy is ignored.
- `abort` (or `reset` asserted) mid-load returns to IDLE with reset values. A partially loaded CB is left as-is; the next `start` reprograms from CB 0.
- `abort` and `start` in the same IDLE cycle: `abort` wins, stay IDLE.

## Timing
- `start` at edge N -> FETCH at N+1 with `word_ready`=1; `prgm_b` falls at N+1.
- Word handshake at edge M -> first `bit_valid` at M+1.
- Back-to-back words: each word costs exactly one FETCH bubble cycle.
- With zero stall, one CB takes (BITS_PER_CB/WORD_W)·(WORD_W+1)+1 cycles: 100 for the defaults.
- A full load (defaults) takes 1 + 2·100 + 1 = 202 cycles from `start` to the `done` pulse.
- Outputs are registered; no combinational path from inputs to outputs, except `word_ready`, which is a state decode.

## Structure
- Shared package `cb_cfg_pkg`:
  - state enum (IDLE, FETCH, SHIFT, GAP, DONE)
  - default constants `CB_BITS_DEFAULT`=96 and `CB_NUM_DEFAULT`=2
  - width helper for the counters
- One natural sub-module: `cfg_word_serializer`, a WORD_W parallel-load LSB-first shift register with a bit-remaining counter and an `empty` flag. The FSM and CB/bit counters stay in the top level.

## Test plan
- Nominal: NUM_CB=2, words 0x00000001, 0x00000000, 0x80000000 repeated per CB, always valid -> `bit_valid` bits 0, 95, 96 and 191 equal 1 and all others 0; `cb_adv` pulses twice; `done` at cycle 202; `prgm_b` low for 200 cycles.
- Source stall: drop `word_valid` for 7 cycles before the second word -> bit stream is identical, `done` is 7 cycles later, and `bit_valid` is 0 throughout the stall.
- Abort: assert `abort` at bit 50 of CB 0 -> next cycle IDLE with `prgm_b`=1, `cb_index`=0; a following `start` completes normally.
- Async reset: drive `reset` low mid-SHIFT between clock edges -> outputs reach reset values immediately, without waiting for a clock edge.
- `start` while busy: pulse `start` at cycle 30 -> no effect, `done` at the nominal cycle.
- Parameter corner: NUM_CB=1, BITS_PER_CB=32 -> exactly one FETCH, 32 bits, GAP, DONE; `done` at cycle 36.
